// File: rtl/tx_chan_pkt_arbiter_pkg.sv
// Shared types and the round-robin search helper for the TX channel packet arbiter.
package tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Widest configuration the helper supports; narrower arbiters zero-pad their requests.
    localparam int MAX_CH      = 16;
    localparam int MAX_CH_ID_W = 4;

    // First set bit of req strictly above last, wrapping to the lowest set bit.
    // Unused (padded) request bits are zero, so the wrap happens at the real channel count.
    function automatic logic [MAX_CH_ID_W-1:0] rr_next(
        input logic [MAX_CH-1:0]      req,
        input logic [MAX_CH_ID_W-1:0] last
    );
        logic found;
        rr_next = '0;
        found   = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (!found && req[i] && (i > int'(last))) begin
                rr_next = MAX_CH_ID_W'(i);
                found   = 1'b1;
            end
        end
        for (int i = 0; i < MAX_CH; i++) begin
            if (!found && req[i]) begin
                rr_next = MAX_CH_ID_W'(i);
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/tx_chan_pkt_arbiter_if.sv
// Per-channel AVST input streams and the merged AVST output stream of the TX arbiter.
interface tx_chan_pkt_arbiter_if #(
    parameter int NUM_CH           = 8,
    parameter int AVST_DATA_WIDTH  = 128,
    parameter int AVST_EMPTY_WIDTH = 4
);
    localparam int CH_ID_WIDTH = $clog2(NUM_CH);

    // A beat transfers in any cycle where valid and ready are both high (ready latency 0);
    // valid never waits on ready, and the data/sop/eop/empty fields are only meaningful with valid.
    logic [NUM_CH-1:0]                  in_st_valid;
    logic [NUM_CH-1:0]                  in_st_sop;
    logic [NUM_CH-1:0]                  in_st_eop;
    logic [NUM_CH*AVST_DATA_WIDTH-1:0]  in_st_data;
    logic [NUM_CH*AVST_EMPTY_WIDTH-1:0] in_st_empty;
    logic [NUM_CH-1:0]                  in_st_ready;

    logic                               out_st_valid;
    logic                               out_st_sop;
    logic                               out_st_eop;
    logic [AVST_DATA_WIDTH-1:0]         out_st_data;
    logic [AVST_EMPTY_WIDTH-1:0]        out_st_empty;
    logic [CH_ID_WIDTH-1:0]             out_st_chan;
    logic                               out_st_ready;

    modport slave (
        input  in_st_valid, in_st_sop, in_st_eop, in_st_data, in_st_empty,
        output in_st_ready,
        output out_st_valid, out_st_sop, out_st_eop, out_st_data, out_st_empty, out_st_chan,
        input  out_st_ready
    );

    modport master (
        output in_st_valid, in_st_sop, in_st_eop, in_st_data, in_st_empty,
        input  in_st_ready,
        input  out_st_valid, out_st_sop, out_st_eop, out_st_data, out_st_empty, out_st_chan,
        output out_st_ready
    );

endinterface

// File: rtl/tx_chan_pkt_arbiter_rr_arbiter.sv
// Combinational round-robin picker: masked find-first-set above last_grant with wrap.
module rr_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int CH_ID_WIDTH = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]      req,
    input  logic [CH_ID_WIDTH-1:0] last_grant,
    output logic [CH_ID_WIDTH-1:0] pick,
    output logic                   pick_valid
);

    logic [MAX_CH-1:0]      req_pad;
    logic [MAX_CH_ID_W-1:0] last_pad;

    always_comb begin
        req_pad             = '0;
        req_pad[NUM_CH-1:0] = req;
        last_pad            = MAX_CH_ID_W'(last_grant);
        pick                = CH_ID_WIDTH'(rr_next(req_pad, last_pad));
        pick_valid          = |req;
    end

endmodule

// File: rtl/tx_chan_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_CH TX DMA streams into one AVST stream.
module tx_chan_pkt_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_CH           = 8,
    parameter int AVST_DATA_WIDTH  = 128,
    parameter int AVST_EMPTY_WIDTH = 4
) (
    input  logic                   st_clk,
    input  logic                   st_rst_n,
    input  logic [NUM_CH-1:0]      ch_en,
    tx_chan_pkt_arbiter_if.slave   st,
    output logic                   busy,
    output logic [NUM_CH-1:0]      drop_sticky,
    output arb_state_t             dbg_state
);

    localparam int CH_ID_WIDTH = $clog2(NUM_CH);

    arb_state_t             state_q, state_d;
    logic [CH_ID_WIDTH-1:0] grant_q, grant_d;
    logic [CH_ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [NUM_CH-1:0]      drop_sticky_q, drop_sticky_d;

    logic [NUM_CH-1:0]      req;
    logic [NUM_CH-1:0]      stray;
    logic [CH_ID_WIDTH-1:0] pick;
    logic                   pick_valid;

    // ch_en only gates new requests and stray draining; an active grant ignores it.
    assign req   = st.in_st_valid &  st.in_st_sop & ch_en;
    assign stray = st.in_st_valid & ~st.in_st_sop & ch_en;

    rr_arbiter #(
        .NUM_CH      (NUM_CH),
        .CH_ID_WIDTH (CH_ID_WIDTH)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_grant_q),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    always_ff @(posedge st_clk or negedge st_rst_n) begin
        if (!st_rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= CH_ID_WIDTH'(NUM_CH - 1);
            drop_sticky_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            drop_sticky_q <= drop_sticky_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        drop_sticky_d   = drop_sticky_q;
        st.in_st_ready  = '0;
        st.out_st_valid = 1'b0;
        st.out_st_sop   = 1'b0;
        st.out_st_eop   = 1'b0;
        st.out_st_data  = '0;
        st.out_st_empty = '0;
        st.out_st_chan  = '0;

        unique case (state_q)
            IDLE: begin
                // Out-of-packet beats are accepted and thrown away so they cannot wedge a channel.
                st.in_st_ready = stray;
                drop_sticky_d  = drop_sticky_q | stray;
                if (pick_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    state_d      = XFER;
                end
            end
            XFER: begin
                st.out_st_valid         = st.in_st_valid[grant_q];
                st.out_st_sop           = st.in_st_sop[grant_q];
                st.out_st_eop           = st.in_st_eop[grant_q];
                st.out_st_data          = st.in_st_data[int'(grant_q)*AVST_DATA_WIDTH +: AVST_DATA_WIDTH];
                st.out_st_empty         = st.in_st_empty[int'(grant_q)*AVST_EMPTY_WIDTH +: AVST_EMPTY_WIDTH];
                st.out_st_chan          = grant_q;
                st.in_st_ready[grant_q] = st.out_st_ready;
                if (st.in_st_valid[grant_q] && st.out_st_ready && st.in_st_eop[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == XFER);
    assign drop_sticky = drop_sticky_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/tx_chan_pkt_arbiter.md
# tx_chan_pkt_arbiter

Packet-granular round-robin arbiter that merges the NUM_CH per-channel TX DMA FIFO output streams into the single AVST TX stream toward the MAC/timestamp path. Each grant lasts from a start-of-packet beat to its end-of-packet beat, so packets are never interleaved. The block also applies a per-channel enable mask, discards out-of-packet beats, and reports the granted channel on a sideband.

## Interface
Parameters:
- NUM_CH, 8, number of channel streams (2..16)
- AVST_DATA_WIDTH, 128, data width per beat
- AVST_EMPTY_WIDTH, 4, empty-symbol field width
- CH_ID_WIDTH, $clog2(NUM_CH), channel index width (derived, not overridden)

Ports:
- st_clk  in  1  single clock for all ports
- st_rst_n  in  1  reset, asynchronous assert, active-low
- ch_en  in  NUM_CH  per-channel arbitration enable
- in_st_valid  in  NUM_CH  per-channel valid
- in_st_sop / in_st_eop  in  NUM_CH  per-channel start/end of packet
- in_st_data  in  NUM_CH*AVST_DATA_WIDTH  flat, channel i at [i*W +: W]
- in_st_empty  in  NUM_CH*AVST_EMPTY_WIDTH  flat, same packing
- in_st_ready  out  NUM_CH  per-channel ready, ready latency 0
- out_st_valid / out_st_sop / out_st_eop  out  1  merged stream controls
- out_st_data  out  AVST_DATA_WIDTH  merged data
- out_st_empty  out  AVST_EMPTY_WIDTH  merged empty
- out_st_chan  out  CH_ID_WIDTH  channel owning the current beat
- out_st_ready  in  1  downstream ready, ready latency 0
- busy  out  1  high while in the XFER state
- drop_sticky  out  NUM_CH  set when a stray beat was discarded on channel i

## Operation
- FSM with two states: IDLE and XFER.
- IDLE:
  - Request vector req[i] = in_st_valid[i] & in_st_sop[i] & ch_en[i].
  - If any req is set, the round-robin arbiter picks the first requester searching upward from last_grant+1, wrapping at NUM_CH-1 -> 0.
  - On a pick: register grant <= pick, last_grant <= pick, go to XFER.
  - out_st_valid = 0 and no data is consumed in IDLE.
- Stray beats in IDLE: a channel with in_st_valid=1, in_st_sop=0 and ch_en=1 gets in_st_ready[i]=1. The beat is discarded and drop_sticky[i] is set. This does not stop another channel from being picked in the same cycle.
- XFER:
  - Combinational pass-through from channel grant to the output: out_st_* = in_st_*[grant], in_st_ready[grant] = out_st_ready, out_st_chan = grant.
  - All other in_st_ready bits are 0.
  - When out_st_valid & out_st_ready & out_st_eop: go to IDLE.
- Single-beat packets (sop and eop together) complete in one XFER cycle.
- Deasserting ch_en[grant] mid-packet has no effect; the packet completes. ch_en is sampled only in IDLE.
- drop_sticky bits clear only on reset.
- Disabled channels (ch_en=0) get in_st_ready=0 at all times outside their own XFER, so they are backpressured, not drained.

## Timing
- Reset values: state=IDLE, grant=0, last_grant=NUM_CH-1 (so channel 0 wins first), busy=0, drop_sticky=0.
- Outputs in IDLE: all out_st_* = 0, in_st_ready = stray-drain mask only.
- Arbitration bubble: exactly one IDLE cycle between the eop of one packet and the sop of the next. Sustained throughput is L/(L+1) for packets of L beats.
- XFER: zero-cycle latency from input to output. out_st_ready -> in_st_ready is a combinational path.
- Reset assertion mid-packet: FSM goes to IDLE asynchronously. The partial packet is abandoned, and its remaining beats are later drained as stray beats.
- out_st_valid may be 0 within a packet (upstream gaps); the block holds XFER until eop is accepted.

## Structure
- Package tx_arb_pkg holds:
  - typedef enum logic {IDLE, XFER} arb_state_t
  - function rr_next(req, last) returning the wrapped first-set index
- Sub-module rr_arbiter (parameter NUM_CH): combinational masked find-first-set with wrap. Inputs req and last_grant; outputs pick and pick_valid.
- Top level holds the FSM, grant register, output mux, and sticky flags.

## Test plan
- Reset, then channels 0 and 3 both present a 4-beat packet -> ch0 packet out with out_st_chan=0, one bubble cycle, then ch3 packet with out_st_chan=3. busy high during each packet.
- All 8 channels continuously requesting 1-beat packets -> output channel order 0,1,2,…,7,0, and each sop is separated by exactly 2 cycles.
- ch2 packet of 5 beats, out_st_ready toggled 1,0,0,1 repeating -> in_st_ready[2] mirrors out_st_ready, no beat lost or duplicated, state stays XFER until eop.
- ch5 presents valid=1, sop=0 while IDLE -> in_st_ready[5]=1 for that cycle, no output beat, drop_sticky=8'b0010_0000.
- ch_en[1] cleared on the 2nd beat of a 6-beat ch1 packet -> all 6 beats delivered. A following ch1 sop is not granted while ch_en[1]=0.
- st_rst_n pulsed low on the 3rd beat of a ch4 packet -> busy=0 and out_st_valid=0 immediately. After release, the remaining ch4 beats are drained and drop_sticky[4]=1.
